// File: rtl/aq_gemac_link_ctrl.sv
// -----------------------------------------------------------------------------
// aq_gemac_link_ctrl
// Bring-up and link sequencer sitting between system logic and aq_gemac_ipctrl.
// Holds the PHY in reset, lets it settle, then writes BMCR to restart
// auto-negotiation. After that it periodically reads BMSR/ANLPAR to resolve
// link, speed and duplex. A parallel ARP sequencer requests the peer MAC on
// every link-up and gates PEER_ENABLE.
//
// Ports
//   CLK, RST_N          : clock, synchronous active-low reset
//   EMAC_RST            : PHY reset, active high
//   MIIM_REQUEST/WRITE  : one-cycle MIIM request and its direction
//   MIIM_PHY_ADDRESS    : fixed PHY address
//   MIIM_REG_ADDRESS    : register index, held from request to completion
//   MIIM_WDATA          : write data, held from request to completion
//   MIIM_RDATA/BUSY     : read data and busy flag from the MIIM engine
//   ARPC_REQUEST        : ARP cache request
//   ARPC_ENABLE/VALID   : ARP resolved / peer already cached
//   LINK_UP, SPEED_100, FULL_DUPLEX : resolved link state
//   PEER_ENABLE         : peer MAC usable
//   MIIM_ERROR          : sticky MIIM timeout flag
// -----------------------------------------------------------------------------
module aq_gemac_link_ctrl #(
  parameter logic [3:0]  PHY_ADDR     = 4'd1,
  parameter int unsigned RST_CYCLES   = 32'd1000000,
  parameter int unsigned POLL_CYCLES  = 32'd10000000,
  parameter int unsigned MIIM_TIMEOUT = 32'd4096,
  parameter int unsigned ARP_TIMEOUT  = 32'd50000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic        EMAC_RST,
  output logic        MIIM_REQUEST,
  output logic        MIIM_WRITE,
  output logic [3:0]  MIIM_PHY_ADDRESS,
  output logic [3:0]  MIIM_REG_ADDRESS,
  output logic [15:0] MIIM_WDATA,
  input  logic [15:0] MIIM_RDATA,
  input  logic        MIIM_BUSY,
  output logic        ARPC_REQUEST,
  input  logic        ARPC_ENABLE,
  input  logic        ARPC_VALID,
  output logic        LINK_UP,
  output logic        SPEED_100,
  output logic        FULL_DUPLEX,
  output logic        PEER_ENABLE,
  output logic        MIIM_ERROR
);

  typedef enum logic [2:0] {
    S_PRST, S_SETTLE, S_WR_BMCR, S_POLL, S_RD_BMSR, S_RD_ANLPAR, S_MWAIT
  } state_t;

  typedef enum logic [1:0] {A_IDLE, A_REQ, A_DONE} arp_state_t;

  // Terminal counts: a state with terminal count N is left after exactly N cycles.
  localparam logic [31:0] L_RST_TC  = 32'(RST_CYCLES - 32'd1);
  localparam logic [31:0] L_POLL_TC = 32'(POLL_CYCLES - 32'd1);
  localparam logic [31:0] L_MIIM_TC = 32'(MIIM_TIMEOUT - 32'd1);
  localparam logic [31:0] L_ARP_TC  = 32'(ARP_TIMEOUT - 32'd1);

  state_t      r_state, w_state;
  arp_state_t  r_arp_state, w_arp_state;
  logic [31:0] r_cnt, w_cnt, r_arp_cnt, w_arp_cnt;
  logic        r_emac_rst, w_emac_rst;
  logic        r_req, w_req, r_write, w_write, r_seen, w_seen;
  logic [3:0]  r_reg, w_reg;
  logic [15:0] r_wdata, w_wdata;
  logic        r_link, w_link, r_link_d, r_spd, w_spd, r_fd, w_fd, r_err, w_err;
  logic        r_arpc_req, w_arpc_req, r_peer, w_peer, r_gap, w_gap;
  logic        w_unused;

  // Only the BMSR/ANLPAR ability bits matter; the rest of the read data is ignored.
  assign w_unused = ^{MIIM_RDATA[15:9], MIIM_RDATA[4:3], MIIM_RDATA[1:0]};

  // States that issue an MIIM request before handing over to S_MWAIT.
  function automatic logic f_is_issue(input state_t s);
    return (s == S_WR_BMCR) || (s == S_RD_BMSR) || (s == S_RD_ANLPAR);
  endfunction

  // Main sequencer: next state, counter, MIIM request fields and link results.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt + 32'd1;
    w_emac_rst = r_emac_rst;
    w_req      = 1'b0;
    w_write    = r_write;
    w_reg      = r_reg;
    w_wdata    = r_wdata;
    w_seen     = r_seen;
    w_link     = r_link;
    w_spd      = r_spd;
    w_fd       = r_fd;
    w_err      = r_err;
    case (r_state)
      S_PRST: begin
        if (r_cnt == L_RST_TC) begin
          w_state    = S_SETTLE;
          w_emac_rst = 1'b0;
        end else begin
          w_emac_rst = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == L_RST_TC) begin
          w_state = S_WR_BMCR;
        end else begin
          w_state = S_SETTLE;
        end
      end
      S_POLL: begin
        if (r_cnt == L_POLL_TC) begin
          w_state = S_RD_BMSR;
        end else begin
          w_state = S_POLL;
        end
      end
      S_WR_BMCR, S_RD_BMSR, S_RD_ANLPAR: begin
        // The request is high for the one cycle spent here; BUSY may already
        // rise in that cycle, so it is carried into the wait state.
        if (r_req) begin
          w_state = S_MWAIT;
          w_seen  = MIIM_BUSY;
        end else begin
          w_seen  = 1'b0;
        end
      end
      S_MWAIT: begin
        if (r_seen && !MIIM_BUSY) begin
          w_state = S_POLL;
          case (r_reg)
            4'd1: begin
              // Link status and auto-negotiation complete must both be set.
              if (MIIM_RDATA[2] && MIIM_RDATA[5]) begin
                w_state = S_RD_ANLPAR;
              end else begin
                w_link  = 1'b0;
              end
            end
            4'd5: begin
              w_link = 1'b1;
              if (MIIM_RDATA[8]) begin
                {w_spd, w_fd} = 2'b11;
              end else if (MIIM_RDATA[7]) begin
                {w_spd, w_fd} = 2'b10;
              end else if (MIIM_RDATA[6]) begin
                {w_spd, w_fd} = 2'b01;
              end else begin
                {w_spd, w_fd} = 2'b00;
              end
            end
            default: w_state = S_POLL;
          endcase
        end else if (r_cnt == L_MIIM_TC) begin
          w_err   = 1'b1;
          w_link  = 1'b0;
          w_state = S_POLL;
        end else begin
          w_seen  = r_seen | MIIM_BUSY;
        end
      end
      default: begin
        w_state    = S_PRST;
        w_emac_rst = 1'b1;
      end
    endcase
    // Raise the request as the issue state is entered (or later, once BUSY is low).
    if (f_is_issue(w_state) && !r_req && !MIIM_BUSY) begin
      w_req = 1'b1;
      case (w_state)
        S_WR_BMCR: begin
          w_write = 1'b1;
          w_reg   = 4'd0;
          w_wdata = 16'h1200;
        end
        S_RD_BMSR: begin
          w_write = 1'b0;
          w_reg   = 4'd1;
          w_wdata = 16'h0000;
        end
        default: begin
          w_write = 1'b0;
          w_reg   = 4'd5;
          w_wdata = 16'h0000;
        end
      endcase
    end else begin
      w_req = 1'b0;
    end
    if (w_state != r_state) begin
      w_cnt = 32'd0;
    end else begin
      w_cnt = r_cnt + 32'd1;
    end
  end

  // ARP sequencer: request on link rise, retry on timeout, drop on link loss.
  always_comb begin
    w_arp_state = r_arp_state;
    w_arp_cnt   = r_arp_cnt + 32'd1;
    w_arpc_req  = r_arpc_req;
    w_peer      = r_peer;
    w_gap       = r_gap;
    case (r_arp_state)
      A_IDLE: begin
        w_arp_cnt = 32'd0;
        w_gap     = 1'b0;
        if (r_link && !r_link_d) begin
          if (ARPC_VALID) begin
            w_peer      = 1'b1;
            w_arp_state = A_DONE;
          end else begin
            w_arpc_req  = 1'b1;
            w_arp_state = A_REQ;
          end
        end else begin
          w_arpc_req = 1'b0;
          w_peer     = 1'b0;
        end
      end
      A_REQ: begin
        if (!r_link) begin
          w_arpc_req  = 1'b0;
          w_peer      = 1'b0;
          w_arp_state = A_IDLE;
        end else if (ARPC_ENABLE) begin
          w_arpc_req  = 1'b0;
          w_peer      = 1'b1;
          w_arp_state = A_DONE;
        end else if (r_gap) begin
          // One-cycle low gap is over: reassert and restart the hold timer.
          w_arpc_req = 1'b1;
          w_gap      = 1'b0;
          w_arp_cnt  = 32'd0;
        end else if (r_arp_cnt == L_ARP_TC) begin
          w_arpc_req = 1'b0;
          w_gap      = 1'b1;
          w_arp_cnt  = 32'd0;
        end else begin
          w_arpc_req = 1'b1;
        end
      end
      A_DONE: begin
        if (!r_link) begin
          w_peer      = 1'b0;
          w_arp_state = A_IDLE;
        end else begin
          w_peer      = 1'b1;
        end
      end
      default: begin
        w_arpc_req  = 1'b0;
        w_peer      = 1'b0;
        w_arp_state = A_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state     <= S_PRST;
      r_cnt       <= 32'd0;
      r_emac_rst  <= 1'b1;
      r_req       <= 1'b0;
      r_write     <= 1'b0;
      r_reg       <= 4'd0;
      r_wdata     <= 16'h0000;
      r_seen      <= 1'b0;
      r_link      <= 1'b0;
      r_link_d    <= 1'b0;
      r_spd       <= 1'b0;
      r_fd        <= 1'b0;
      r_err       <= 1'b0;
      r_arp_state <= A_IDLE;
      r_arp_cnt   <= 32'd0;
      r_arpc_req  <= 1'b0;
      r_peer      <= 1'b0;
      r_gap       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_emac_rst  <= w_emac_rst;
      r_req       <= w_req;
      r_write     <= w_write;
      r_reg       <= w_reg;
      r_wdata     <= w_wdata;
      r_seen      <= w_seen;
      r_link      <= w_link;
      r_link_d    <= r_link;
      r_spd       <= w_spd;
      r_fd        <= w_fd;
      r_err       <= w_err;
      r_arp_state <= w_arp_state;
      r_arp_cnt   <= w_arp_cnt;
      r_arpc_req  <= w_arpc_req;
      r_peer      <= w_peer;
      r_gap       <= w_gap;
    end
  end

  assign EMAC_RST         = r_emac_rst;
  assign MIIM_REQUEST     = r_req;
  assign MIIM_WRITE       = r_write;
  assign MIIM_PHY_ADDRESS = PHY_ADDR;
  assign MIIM_REG_ADDRESS = r_reg;
  assign MIIM_WDATA       = r_wdata;
  assign ARPC_REQUEST     = r_arpc_req;
  assign LINK_UP          = r_link;
  assign SPEED_100        = r_spd;
  assign FULL_DUPLEX      = r_fd;
  assign PEER_ENABLE      = r_peer;
  assign MIIM_ERROR       = r_err;

endmodule

// File: tb/tb_aq_gemac_link_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aq_gemac_link_ctrl
// Self-checking bench for aq_gemac_link_ctrl with shortened timing parameters.
// A small MIIM engine model answers each request with BUSY high for 3 cycles
// and returns the BMSR/ANLPAR values chosen by the test. Link resolution is
// driven from a vector table; reset, ARP and timeout corners are hand-written.
// -----------------------------------------------------------------------------
module tb_aq_gemac_link_ctrl;

  localparam int RST_C   = 8;
  localparam int POLL_C  = 6;
  localparam int MIIM_TO = 16;
  localparam int ARP_TO  = 40;

  logic        CLK;
  logic        RST_N;
  logic        EMAC_RST, MIIM_REQUEST, MIIM_WRITE;
  logic [3:0]  MIIM_PHY_ADDRESS, MIIM_REG_ADDRESS;
  logic [15:0] MIIM_WDATA, MIIM_RDATA;
  logic        MIIM_BUSY, ARPC_REQUEST, ARPC_ENABLE, ARPC_VALID;
  logic        LINK_UP, SPEED_100, FULL_DUPLEX, PEER_ENABLE, MIIM_ERROR;

  aq_gemac_link_ctrl #(
    .PHY_ADDR(4'd1), .RST_CYCLES(RST_C), .POLL_CYCLES(POLL_C),
    .MIIM_TIMEOUT(MIIM_TO), .ARP_TIMEOUT(ARP_TO)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .EMAC_RST(EMAC_RST),
    .MIIM_REQUEST(MIIM_REQUEST), .MIIM_WRITE(MIIM_WRITE),
    .MIIM_PHY_ADDRESS(MIIM_PHY_ADDRESS), .MIIM_REG_ADDRESS(MIIM_REG_ADDRESS),
    .MIIM_WDATA(MIIM_WDATA), .MIIM_RDATA(MIIM_RDATA), .MIIM_BUSY(MIIM_BUSY),
    .ARPC_REQUEST(ARPC_REQUEST), .ARPC_ENABLE(ARPC_ENABLE), .ARPC_VALID(ARPC_VALID),
    .LINK_UP(LINK_UP), .SPEED_100(SPEED_100), .FULL_DUPLEX(FULL_DUPLEX),
    .PEER_ENABLE(PEER_ENABLE), .MIIM_ERROR(MIIM_ERROR)
  );

  // {bmsr, anlpar} in, {LINK_UP, SPEED_100, FULL_DUPLEX, PEER_ENABLE, ARPC_REQUEST} out
  typedef struct {
    logic [15:0] bmsr;
    logic [15:0] anlpar;
    logic [4:0]  exp;
  } vec_t;

  vec_t        vecs [8];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          hi, lo, n_err;
  logic        bfm_en = 1'b0;
  logic        mon_en = 1'b0;
  logic        req_seen = 1'b0;
  logic [15:0] bmsr_val = 16'h0000;
  logic [15:0] anlpar_val = 16'h0000;
  logic [3:0]  bfm_reg;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  // MIIM engine model: BUSY high for 3 sampled cycles, read data valid at the fall.
  initial begin
    MIIM_BUSY  = 1'b0;
    MIIM_RDATA = 16'h0000;
    forever begin
      @(negedge CLK);
      if (bfm_en && MIIM_REQUEST) begin
        bfm_reg   = MIIM_REG_ADDRESS;
        MIIM_BUSY = 1'b1;
        repeat (3) @(negedge CLK);
        MIIM_RDATA = (bfm_reg == 4'd1) ? bmsr_val : ((bfm_reg == 4'd5) ? anlpar_val : 16'h0000);
        MIIM_BUSY  = 1'b0;
        fall_cyc   = cyc;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en && ARPC_REQUEST) req_seen = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic probe(input int idx);
    case (idx)
      0:       return MIIM_REQUEST;
      1:       return ARPC_REQUEST;
      2:       return ~LINK_UP;
      default: return ~MIIM_BUSY;
    endcase
  endfunction

  // Bounded wait on a negedge-sampled condition; an expired bound is a failed check.
  task automatic wait_until(input int idx, input int bound, input string name);
    int n = 0;
    while (probe(idx) !== 1'b1 && n < bound) begin
      @(negedge CLK);
      n++;
    end
    check(name, {31'd0, probe(idx)}, 32'd1);
  endtask

  task automatic check_reset(input string name);
    check(name, {3'd0, EMAC_RST, MIIM_REQUEST, MIIM_WRITE, MIIM_REG_ADDRESS, MIIM_WDATA,
                 ARPC_REQUEST, LINK_UP, SPEED_100, FULL_DUPLEX, PEER_ENABLE, MIIM_ERROR},
          {3'd0, 1'b1, 28'd0});
    check({name, "_phy_addr"}, {28'd0, MIIM_PHY_ADDRESS}, 32'd1);
  endtask

  // Release reset at a negedge and check PHY reset width and the BMCR write.
  task automatic startup();
    int h = 0;
    int n = 0;
    RST_N = 1'b1;
    while (EMAC_RST === 1'b1 && h < 50) begin
      h++;
      @(negedge CLK);
    end
    check("emac_rst_width", h, RST_C);
    while (MIIM_REQUEST !== 1'b1 && n < 50) begin
      n++;
      @(negedge CLK);
    end
    check("first_req_delay", n, RST_C);
    check("bmcr_write_fields", {11'd0, MIIM_WRITE, MIIM_REG_ADDRESS, MIIM_WDATA},
          {11'd0, 1'b1, 4'd0, 16'h1200});
    @(negedge CLK);
    check("req_one_cycle", {31'd0, MIIM_REQUEST}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0024, 16'h0140, 5'b11110};
    vecs[1] = '{16'h0024, 16'h0020, 5'b10010};
    vecs[2] = '{16'h0024, 16'h0080, 5'b11010};
    vecs[3] = '{16'h0024, 16'h0040, 5'b10110};
    vecs[4] = '{16'h0024, 16'h01C0, 5'b11110};
    vecs[5] = '{16'h0004, 16'h0140, 5'b01100};
    vecs[6] = '{16'h0020, 16'h0000, 5'b01100};
    vecs[7] = '{16'h782D, 16'h0060, 5'b10110};

    RST_N       = 1'b0;
    ARPC_ENABLE = 1'b0;
    ARPC_VALID  = 1'b1;
    repeat (3) @(negedge CLK);
    check_reset("reset_state");
    bfm_en     = 1'b1;
    bmsr_val   = vecs[0].bmsr;
    anlpar_val = vecs[0].anlpar;
    startup();

    // Link resolution table with the peer already cached.
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bmsr_val   = vecs[i].bmsr;
      anlpar_val = vecs[i].anlpar;
      repeat (60) @(negedge CLK);
      check($sformatf("vec%0d_link", i),
            {27'd0, LINK_UP, SPEED_100, FULL_DUPLEX, PEER_ENABLE, ARPC_REQUEST},
            {27'd0, vecs[i].exp});
    end
    mon_en = 1'b0;
    check("cached_peer_no_request", {31'd0, req_seen}, 32'd0);

    // Link loss reported by a BMSR read.
    bmsr_val = 16'h0000;
    wait_until(2, 100, "drop_wait");
    check("drop_latency", cyc - fall_cyc, 32'd1);
    @(negedge CLK);
    check("drop_peer_req", {30'd0, PEER_ENABLE, ARPC_REQUEST}, 32'd0);

    // ARP request answered 20 cycles after it rose.
    ARPC_VALID = 1'b0;
    bmsr_val   = 16'h0024;
    anlpar_val = 16'h0140;
    wait_until(1, 100, "arp_req_wait");
    hi = 0;
    while (ARPC_REQUEST === 1'b1 && hi < 100) begin
      hi++;
      if (hi == 20) ARPC_ENABLE = 1'b1;
      @(negedge CLK);
    end
    check("arp_req_width", hi, 32'd20);
    check("arp_peer_after_enable", {30'd0, PEER_ENABLE, ARPC_REQUEST}, 32'd2);
    ARPC_ENABLE = 1'b0;
    repeat (5) @(negedge CLK);
    check("arp_done_hold", {30'd0, PEER_ENABLE, ARPC_REQUEST}, 32'd2);

    // Drop again, then let the request time out once before answering.
    bmsr_val = 16'h0000;
    wait_until(2, 100, "drop2_wait");
    repeat (2) @(negedge CLK);
    check("drop2_peer", {31'd0, PEER_ENABLE}, 32'd0);
    bmsr_val = 16'h0024;
    wait_until(1, 100, "retry_req_wait");
    hi = 0;
    while (ARPC_REQUEST === 1'b1 && hi < 200) begin
      hi++;
      @(negedge CLK);
    end
    check("arp_retry_hold", hi, ARP_TO);
    lo = 0;
    while (ARPC_REQUEST !== 1'b1 && lo < 10) begin
      lo++;
      @(negedge CLK);
    end
    check("arp_retry_gap", lo, 32'd1);
    ARPC_ENABLE = 1'b1;
    @(negedge CLK);
    check("arp_retry_done", {30'd0, PEER_ENABLE, ARPC_REQUEST}, 32'd2);
    ARPC_ENABLE = 1'b0;

    // MIIM engine stops answering: timeout, link down, polling continues.
    @(posedge CLK);
    #2 bfm_en = 1'b0;
    wait_until(3, 20, "busy_idle_wait");
    wait_until(0, 100, "to_req_wait");
    n_err = 0;
    repeat (MIIM_TO) begin
      @(negedge CLK);
      if (MIIM_ERROR) n_err++;
    end
    check("to_error_early", n_err, 32'd0);
    @(negedge CLK);
    check("to_error_link", {30'd0, MIIM_ERROR, LINK_UP}, 32'd2);
    wait_until(0, 30, "to_next_poll");
    check("to_next_poll_fields", {27'd0, MIIM_WRITE, MIIM_REG_ADDRESS}, {27'd0, 1'b0, 4'd1});
    repeat (3) @(negedge CLK);
    check("to_sticky_peer", {30'd0, MIIM_ERROR, PEER_ENABLE}, 32'd2);

    // Reset in the middle of an MIIM transaction.
    @(posedge CLK);
    #2 bfm_en = 1'b1;
    wait_until(0, 60, "mid_req_wait");
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    check_reset("mid_reset_state");
    @(negedge CLK);
    startup();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aq_gemac_link_ctrl.md
Name: aq_gemac_link_ctrl

Overview:
- Bring-up and link sequencer between the system logic and aq_gemac_ipctrl.
- Holds the PHY in reset, then releases it and configures auto-negotiation over the MIIM request interface.
- Polls link status and resolves speed/duplex, then drives the ARP cache request handshake.
- Gates the UDP peer-enable once the peer MAC is resolved.
- Replaces ad-hoc top-level ARP state logic.

Parameters:
- PHY_ADDR, 4'd1, MIIM PHY address used for every access.
- RST_CYCLES, 1000000, cycles EMAC_RST is held high, and also the settle wait after release.
- POLL_CYCLES, 10000000, idle cycles between status polls.
- MIIM_TIMEOUT, 4096, max cycles to wait for one MIIM transaction.
- ARP_TIMEOUT, 50000000, max cycles ARPC_REQUEST is held before a retry.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- EMAC_RST  out  1  PHY reset, active high
- MIIM_REQUEST  out  1  one-cycle MIIM transaction request
- MIIM_WRITE  out  1  1 = write, 0 = read; valid with MIIM_REQUEST
- MIIM_PHY_ADDRESS  out  4  always PHY_ADDR
- MIIM_REG_ADDRESS  out  4  register index
- MIIM_WDATA  out  16  write data
- MIIM_RDATA  in  16  read data, valid when MIIM_BUSY falls
- MIIM_BUSY  in  1  MIIM engine busy
- ARPC_REQUEST  out  1  ARP cache request
- ARPC_ENABLE  in  1  ARP resolution done
- ARPC_VALID  in  1  cache already holds the peer
- LINK_UP  out  1  registered BMSR.2
- SPEED_100  out  1  1 = 100 Mb/s, 0 = 10 Mb/s
- FULL_DUPLEX  out  1  resolved duplex
- PEER_ENABLE  out  1  peer MAC usable
- MIIM_ERROR  out  1  sticky MIIM timeout flag

Behaviour:
- Reset (RST_N=0 sampled at a CLK edge):
  - EMAC_RST=1, state=S_PRST, counter=0.
  - All other outputs 0.
  - Reset mid-transaction abandons it; MIIM_REQUEST is low the following cycle.
- Main FSM:
  - S_PRST: count RST_CYCLES, then EMAC_RST=0 -> S_SETTLE.
  - S_SETTLE: count RST_CYCLES -> S_WR_BMCR.
  - S_WR_BMCR: when MIIM_BUSY=0, pulse MIIM_REQUEST with WRITE=1, REG=0, WDATA=16'h1200 -> S_MWAIT (return S_POLL).
  - S_POLL: count POLL_CYCLES -> S_RD_BMSR.
  - S_RD_BMSR: read REG=1 via S_MWAIT.
    - Captured bit2=1 and bit5=1: -> S_RD_ANLPAR.
    - Otherwise: LINK_UP=0 -> S_POLL.
  - S_RD_ANLPAR: read REG=5 via S_MWAIT, then resolve (priority order):
    - bit8 -> 100/FD
    - bit7 -> 100/HD
    - bit6 -> 10/FD
    - else -> 10/HD
    - Then LINK_UP=1, SPEED_100 and FULL_DUPLEX updated in the same cycle -> S_POLL.
- MIIM handshake (S_MWAIT):
  - MIIM_REQUEST is exactly one cycle wide and is only issued when MIIM_BUSY=0.
  - Wait for MIIM_BUSY=1, then MIIM_BUSY=0. Capture MIIM_RDATA on the cycle BUSY is sampled 0 after being 1.
  - MIIM_WRITE, REG and WDATA are held stable from the request until completion.
  - Timeout: MIIM_TIMEOUT cycles without completion -> MIIM_ERROR=1 (sticky until reset), treat as link down, -> S_POLL.
- ARP sub-FSM (runs in parallel):
  - A_IDLE: on the LINK_UP 0->1 edge:
    - If ARPC_VALID=1: PEER_ENABLE=1 -> A_DONE.
    - Else -> A_REQ.
  - A_REQ: ARPC_REQUEST=1.
    - ARPC_ENABLE=1: drop request, PEER_ENABLE=1 -> A_DONE.
    - ARP_TIMEOUT reached: ARPC_REQUEST=0 for one cycle, reassert, restart the timer.
  - A_DONE: hold PEER_ENABLE=1.
  - LINK_UP falling, in any A state: ARPC_REQUEST=0, PEER_ENABLE=0 -> A_IDLE the next cycle. If the link drops and recovers during A_REQ, the request restarts.
- Counters:
  - 32-bit, clear on every state entry.
  - A terminal count of N means exactly N cycles spent in the state.

Test Plan:
- Reset release with RST_CYCLES=8 -> EMAC_RST high for 8 cycles, low afterwards; first MIIM_REQUEST occurs 8 cycles later with WRITE=1, REG=0, WDATA=16'h1200.
- Model BUSY high for 3 cycles per access; BMSR=16'h0024, ANLPAR=16'h0140 -> LINK_UP=1, SPEED_100=1, FULL_DUPLEX=1. Repeat with ANLPAR=16'h0020 -> SPEED_100=0, FULL_DUPLEX=0.
- BMSR=16'h0000 after link-up -> LINK_UP=0, PEER_ENABLE=0, ARPC_REQUEST=0 within 1 cycle of the captured read.
- ARPC_VALID=0, ARPC_ENABLE asserted 20 cycles after the request -> ARPC_REQUEST high exactly 20 cycles, PEER_ENABLE=1 the next cycle. With ARPC_VALID=1 -> no request issued, PEER_ENABLE=1.
- MIIM_BUSY never rises, MIIM_TIMEOUT=16 -> MIIM_ERROR=1 after 16 cycles, FSM returns to S_POLL and the poll continues.
- RST_N low during S_MWAIT -> all outputs return to reset values and EMAC_RST=1 on the next edge.
